// File: rtl/gym_spin_tile_mover.sv
// gym_spin_tile_mover: multi-tile spin movement engine for the gym overworld.
// Looks up the landing tile's kind, then slides the character tile by tile at
// STEP_PX pixels per frame_tick until a stop, wall, edge or traversal limit.
// Ports:
//   Clk, Reset            - clock, async active-high reset
//   frame_tick            - one pulse per video frame (advances motion)
//   start, xleft_in/ytop_in - arrival pulse and pixel position
//   tile_col/tile_row     - registered tile-map request
//   tile_kind             - combinational tile-map response
//   busy, done            - run in progress / end-of-run pulse
//   spin_direction        - facing: 0 up, 1 down, 2 left, 3 right
//   xleft_next_out/ytop_next_out - current character pixel position
module gym_spin_tile_mover #(
    parameter int COORD_W   = 10,
    parameter int TILE_PX   = 16,
    parameter int STEP_PX   = 4,
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int MAX_TILES = 64
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_tick,
    input  logic                     start,
    input  logic [COORD_W-1:0]       xleft_in,
    input  logic [COORD_W-1:0]       ytop_in,
    output logic [$clog2(COLS)-1:0]  tile_col,
    output logic [$clog2(ROWS)-1:0]  tile_row,
    input  logic [2:0]               tile_kind,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               spin_direction,
    output logic [COORD_W-1:0]       xleft_next_out,
    output logic [COORD_W-1:0]       ytop_next_out
);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int TSH = $clog2(TILE_PX);
    localparam int OW  = TSH + 1;
    localparam int NW  = $clog2(MAX_TILES + 1);

    localparam logic [OW-1:0]      STEP_O = OW'(STEP_PX);
    localparam logic [OW-1:0]      TILE_O = OW'(TILE_PX);
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP_PX);
    localparam logic [NW-1:0]      MAX_N  = NW'(MAX_TILES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_AHEAD,
        S_MOVE,
        S_DONE
    } state_t;

    state_t          state;
    logic            moving;
    logic [NW-1:0]   tiles;
    logic [OW-1:0]   offset;

    logic            aligned;
    logic            is_arrow;
    logic            go;
    logic [1:0]      dir_l;
    logic            in_range;
    logic [CW-1:0]   ncol;
    logic [RW-1:0]   nrow;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic [OW-1:0]   noff;

    assign aligned = (xleft_in[TSH-1:0] == '0) && (ytop_in[TSH-1:0] == '0);

    // Tile decision in LOOKUP: new facing and the neighbour in that facing.
    always_comb begin
        is_arrow = 1'b0;
        go       = 1'b0;
        dir_l    = spin_direction;
        case (tile_kind)
            3'd1, 3'd2, 3'd3, 3'd4: begin
                is_arrow = 1'b1;
                go       = 1'b1;
                // kinds 1..4 map to facings 0..3 (4 wraps through 2'b00)
                dir_l    = tile_kind[1:0] - 2'd1;
            end
            3'd0, 3'd7: go = moving;
            default:    go = 1'b0;
        endcase

        ncol     = tile_col;
        nrow     = tile_row;
        in_range = 1'b1;
        case (dir_l)
            2'd0: if (tile_row == '0) in_range = 1'b0;
                  else nrow = tile_row - RW'(1);
            2'd1: if (tile_row == RW'(ROWS - 1)) in_range = 1'b0;
                  else nrow = tile_row + RW'(1);
            2'd2: if (tile_col == '0) in_range = 1'b0;
                  else ncol = tile_col - CW'(1);
            default: if (tile_col == CW'(COLS - 1)) in_range = 1'b0;
                     else ncol = tile_col + CW'(1);
        endcase
    end

    // Position after one frame step along the current facing.
    always_comb begin
        nx = xleft_next_out;
        ny = ytop_next_out;
        case (spin_direction)
            2'd0:    ny = ytop_next_out - STEP_C;
            2'd1:    ny = ytop_next_out + STEP_C;
            2'd2:    nx = xleft_next_out - STEP_C;
            default: nx = xleft_next_out + STEP_C;
        endcase
        noff = offset + STEP_O;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= S_IDLE;
            moving         <= 1'b0;
            tiles          <= '0;
            offset         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            spin_direction <= 2'd0;
            tile_col       <= '0;
            tile_row       <= '0;
            xleft_next_out <= '0;
            ytop_next_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && aligned) begin
                        xleft_next_out <= xleft_in;
                        ytop_next_out  <= ytop_in;
                        moving         <= 1'b0;
                        tiles          <= '0;
                        busy           <= 1'b1;
                        tile_col       <= xleft_in[TSH +: CW];
                        tile_row       <= ytop_in[TSH +: RW];
                        state          <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    spin_direction <= dir_l;
                    if (is_arrow) moving <= 1'b1;
                    if (!go || !in_range || tiles == MAX_N) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tile_col <= ncol;
                        tile_row <= nrow;
                        state    <= S_AHEAD;
                    end
                end
                S_AHEAD: begin
                    if (tile_kind == 3'd6) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        offset <= '0;
                        state  <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (frame_tick) begin
                        xleft_next_out <= nx;
                        ytop_next_out  <= ny;
                        offset         <= noff;
                        if (noff == TILE_O) begin
                            tiles    <= tiles + NW'(1);
                            tile_col <= nx[TSH +: CW];
                            tile_row <= ny[TSH +: RW];
                            state    <= S_LOOKUP;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gym_spin_tile_mover.sv
// Scoreboard bench for gym_spin_tile_mover: a tile-by-tile reference model
// predicts each run's end state; a monitor checks it on every done pulse.
module tb_gym_spin_tile_mover;
    localparam int MAXT = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] xleft_in = '0;
    logic [9:0] ytop_in = '0;
    logic [5:0] tile_col;
    logic [4:0] tile_row;
    logic [2:0] tile_kind;
    logic       busy;
    logic       done;
    logic [1:0] spin_direction;
    logic [9:0] xleft_next_out;
    logic [9:0] ytop_next_out;

    gym_spin_tile_mover #(
        .COORD_W(10), .TILE_PX(16), .STEP_PX(4),
        .COLS(40), .ROWS(30), .MAX_TILES(MAXT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
        .xleft_in(xleft_in), .ytop_in(ytop_in),
        .tile_col(tile_col), .tile_row(tile_row), .tile_kind(tile_kind),
        .busy(busy), .done(done), .spin_direction(spin_direction),
        .xleft_next_out(xleft_next_out), .ytop_next_out(ytop_next_out)
    );

    always #5 Clk = ~Clk;

    logic [2:0] map [30][40];
    assign tile_kind = (tile_row < 5'd30 && tile_col < 6'd40)
                       ? map[tile_row][tile_col] : 3'd0;

    // free-running frame pulse every 4 cycles
    always begin
        repeat (3) @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    end

    typedef struct {
        int x;
        int y;
        int dir;
        int steps;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    int cur_dir = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk whole tiles using the tile rules directly.
    function automatic void model(input int sx, input int sy, inout int dir,
                                  output int fx, output int fy,
                                  output int steps);
        int x, y, n, c, r, k, dx, dy, nc, nr;
        bit mv;
        x = sx; y = sy; n = 0; mv = 0; steps = 0;
        for (int it = 0; it < 1000; it++) begin
            c = x / 16;
            r = y / 16;
            k = int'(map[r][c]);
            if (k >= 1 && k <= 4) begin
                dir = k - 1;
                mv = 1;
            end else if (!((k == 0 || k == 7) && mv)) begin
                break;
            end
            if (n == MAXT) break;
            dx = 0; dy = 0;
            case (dir)
                0: dy = -1;
                1: dy = 1;
                2: dx = -1;
                default: dx = 1;
            endcase
            nc = c + dx;
            nr = r + dy;
            if (nc < 0 || nc > 39 || nr < 0 || nr > 29) break;
            if (map[nr][nc] == 3'd6) break;
            x += 16 * dx;
            y += 16 * dy;
            n++;
            steps += 4;
        end
        fx = x;
        fy = y;
    endfunction

    // Monitor: counts position changes during a run, checks at done.
    logic       pbusy = 1'b0;
    int         steps = 0;
    logic [9:0] px = '0;
    logic [9:0] py = '0;
    always @(negedge Clk) begin
        if (Reset) begin
            pbusy = 1'b0;
            steps = 0;
        end else begin
            if (busy && !pbusy) steps = 0;
            else if (busy && (xleft_next_out != px || ytop_next_out != py))
                steps++;
            px = xleft_next_out;
            py = ytop_next_out;
            pbusy = busy;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("x", int'(xleft_next_out), e.x);
                    check("y", int'(ytop_next_out), e.y);
                    check("dir", int'(spin_direction), e.dir);
                    check("steps", steps, e.steps);
                end
            end
        end
    end

    task automatic push_exp(input int x, input int y);
        exp_t e;
        model(x, y, cur_dir, e.x, e.y, e.steps);
        e.dir = cur_dir;
        q.push_back(e);
    endtask

    task automatic issue_start(input int x, input int y);
        @(negedge Clk);
        xleft_in = 10'(x);
        ytop_in = 10'(y);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge Clk);
        end
        if (!seen) check("done_timeout", 0, 1);
        @(negedge Clk);
    endtask

    task automatic run(input int x, input int y);
        push_exp(x, y);
        issue_start(x, y);
        wait_done();
    endtask

    task automatic clear_map();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                map[r][c] = 3'd0;
    endtask

    task automatic random_map();
        int v;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++) begin
                v = int'($urandom_range(0, 9));
                if (v < 4) map[r][c] = 3'd0;
                else if (v == 4) map[r][c] = 3'd7;
                else if (v < 9) map[r][c] = 3'(v - 4);
                else map[r][c] = 3'($urandom_range(5, 6));
            end
    endtask

    initial begin
        clear_map();
        repeat (3) @(negedge Clk);
        check("rst_busy", int'(busy), 0);
        check("rst_pos", int'(xleft_next_out) + int'(ytop_next_out), 0);
        check("rst_tile", int'(tile_col) + int'(tile_row), 0);
        Reset = 1'b0;

        // floor start: timing of busy/done
        push_exp(160, 160);
        issue_start(160, 160);
        check("floor_busy1", int'(busy), 1);
        check("floor_done1", int'(done), 0);
        @(negedge Clk);
        check("floor_busy2", int'(busy), 1);
        check("floor_done2", int'(done), 1);
        @(negedge Clk);
        check("floor_busy3", int'(busy), 0);
        check("floor_done3", int'(done), 0);
        repeat (10) @(negedge Clk);
        check("floor_nomove", int'(xleft_next_out), 160);

        // right-arrow run to a stop tile
        map[23][28] = 3'd4;
        map[23][31] = 3'd5;
        run(448, 368);
        check("right_final_x", int'(xleft_next_out), 496);

        // edge stop and wall stop
        clear_map();
        map[0][39] = 3'd4;
        run(624, 0);
        map[10][10] = 3'd1;
        map[9][10] = 3'd6;
        run(160, 160);

        // 2x2 arrow loop bounded by the tile limit
        clear_map();
        map[5][5] = 3'd4;
        map[5][6] = 3'd2;
        map[6][6] = 3'd3;
        map[6][5] = 3'd1;
        run(80, 80);

        // misaligned start is ignored
        issue_start(15, 79);
        repeat (4) @(negedge Clk);
        check("misaligned_busy", int'(busy), 0);

        // start while busy is ignored
        clear_map();
        map[23][28] = 3'd4;
        map[23][31] = 3'd5;
        push_exp(448, 368);
        issue_start(448, 368);
        repeat (12) @(negedge Clk);
        issue_start(160, 160);
        wait_done();

        // reset mid-run
        push_exp(448, 368);
        issue_start(448, 368);
        for (int i = 0; i < 500; i++) begin
            if (xleft_next_out == 10'd456) break;
            @(negedge Clk);
        end
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_x", int'(xleft_next_out), 0);
        check("mid_rst_y", int'(ytop_next_out), 0);
        check("mid_rst_dir", int'(spin_direction), 0);
        check("mid_rst_tile", int'(tile_col) + int'(tile_row), 0);
        q.delete();
        cur_dir = 0;
        @(negedge Clk);
        Reset = 1'b0;
        run(448, 368);

        // randomized maps and starts
        for (int m = 0; m < 4; m++) begin
            random_map();
            for (int i = 0; i < 10; i++)
                run(16 * int'($urandom_range(0, 39)),
                    16 * int'($urandom_range(0, 29)));
        end

        repeat (5) @(negedge Clk);
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
